hash_byte_streamer: RTL and testbench
=====================================

# hash_byte_streamer

Receiving end of the validator's result interface. Accepts 128-bit hashes on a valid-only strobe (no backpressure upstream), buffers them in an internal FIFO and emits each hash as 16 bytes, MSB first, on a ready/valid byte stream toward the host link. Hashes that arrive while the FIFO is full are dropped and counted, never stalled.

## Interface
- DEPTH, 8: FIFO capacity in hashes; power of two, 2..64.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- i_valid  in  1  one-cycle strobe; i_hash is valid this cycle.
- i_hash  in  128  hash word from the validator.
- o_byte  out  8  current output byte.
- o_byte_valid  out  1  o_byte is valid.
- i_byte_ready  in  1  sink accepts o_byte this cycle.
- o_last  out  1  high with byte 15 of a hash.
- o_level  out  $clog2(DEPTH)+1  hashes held in FIFO (excludes the hash being sent).
- o_overflow  out  1  sticky: at least one hash dropped since reset.
- o_drop_count  out  16  dropped hashes, saturating at 16'hFFFF.

## Operation
- Transfer = o_byte_valid && i_byte_ready on a rising edge.
- FIFO write: when i_valid and (o_level < DEPTH or a pop occurs the same cycle). Otherwise the hash is dropped: o_overflow <= 1, o_drop_count increments unless already 16'hFFFF.
- FIFO pop: only when the FSM loads the shift register. No write-to-output bypass; a hash always passes through the FIFO.
- FSM states: IDLE, SEND.
  - IDLE: o_byte_valid=0. If o_level != 0: pop head into 128-bit shift register, byte index <= 0, go to SEND.
  - SEND: o_byte_valid=1, o_byte = shreg[127:120], o_last = (index == 15).
    - Transfer with index < 15: shreg <<= 8, index++.
    - Transfer with index == 15: if o_level != 0, pop next hash, index <= 0, stay in SEND (no bubble); else go to IDLE.
    - No transfer: hold state; o_byte, o_last stable.
- Byte order: byte k carries hash[127-8k -: 8]; byte 0 = hash[127:120], byte 15 = hash[7:0].
- o_byte_valid, once high, never drops before a transfer (no retraction).
- o_level: +1 per accepted write, -1 per pop, unchanged when both occur.
- Simultaneous i_valid with full FIFO and a pop: write accepted, no drop.

## Timing
- Reset (rst=0 at an edge): FSM=IDLE, FIFO empty, o_byte_valid=0, o_byte=8'h00, o_last=0, o_level=0, o_overflow=0, o_drop_count=0. In-flight hash and buffered hashes discarded; no partial continuation after reset release.
- i_valid ignored while rst=0.
- Latency, empty block: i_valid in cycle N -> o_level=1 in N+1 -> byte 0 valid in N+2 (o_level back to 0 in N+2).
- Throughput: 1 byte/cycle with i_byte_ready held high; consecutive hashes contiguous (byte 15 of hash A in cycle T, byte 0 of hash B in T+1) if B was written before T.
- Sustained input above 1 hash / 16 cycles overflows after DEPTH+1 hashes buffered (DEPTH in FIFO + 1 in shreg).
- All outputs registered.

## Test plan
- Single hash 128'h000102...0E0F, ready held 1 -> bytes 00,01,...,0F on consecutive cycles starting 2 cycles after i_valid; o_last only on 0F; then o_byte_valid=0.
- Three hashes on back-to-back cycles, ready=1 -> 48 contiguous bytes, no bubble, o_last at bytes 15/31/47, o_level peaks at 2.
- Backpressure: ready toggles 1,0,0,1 repeating -> o_byte/o_last stable during low ready, no byte lost or duplicated, order preserved.
- Overflow, DEPTH=8, ready=0: 12 hashes on consecutive cycles -> first 9 kept (1 in shreg, 8 in FIFO), o_drop_count=3, o_overflow=1; after ready=1, exactly 9 hashes emitted in order; o_overflow stays 1.
- Full + pop same cycle: FIFO full, i_valid coincides with byte-15 transfer -> hash accepted, o_drop_count unchanged, o_level unchanged.
- Reset at byte 7 of a hash with 3 buffered -> next cycle o_byte_valid=0, o_level=0, counters 0; after release, no bytes until new i_valid.

Source files
------------

// File: rtl/hash_byte_streamer.sv
// Buffers 128-bit hashes from a valid-only strobe in a FIFO and serializes each
// one as 16 bytes, MSB first, on a ready/valid byte stream. Overflowing hashes are dropped and counted.
module hash_byte_streamer #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic [127:0]               i_hash,
  output logic [7:0]                 o_byte,
  output logic                       o_byte_valid,
  input  logic                       i_byte_ready,
  output logic                       o_last,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_overflow,
  output logic [15:0]                o_drop_count,
  output logic                       o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  // Byte handshake: a byte moves on a rising edge where o_byte_valid and
  // i_byte_ready are both high; o_byte_valid never drops before that happens.

  state_e          state_q, state_d;
  logic [127:0]    shreg_q, shreg_d;
  logic [3:0]      idx_q, idx_d;
  logic            last_q, last_d;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q;
  logic [15:0]     drop_q;
  logic [127:0]    mem_q [DEPTH];

  logic xfer, pop, wr_en, full;

  assign xfer  = (state_q == SEND) && i_byte_ready;
  assign full  = (level_q == LW'(DEPTH));
  assign wr_en = i_valid && (!full || pop);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    last_d  = last_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          idx_d   = 4'd0;
          last_d  = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx_q != 4'd15) begin
            shreg_d = {shreg_q[119:0], 8'h00};
            idx_d   = idx_q + 4'd1;
            last_d  = (idx_q == 4'd14);
          end else if (level_q != '0) begin
            // Back-to-back hashes: reload straight from the FIFO, no bubble.
            pop     = 1'b1;
            shreg_d = mem_q[rd_ptr_q];
            idx_d   = 4'd0;
            last_d  = 1'b0;
          end else begin
            last_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q + LW'(wr_en) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      level_q  <= level_d;
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (i_valid && !wr_en) begin
        overflow_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem_q[wr_ptr_q] <= i_hash;
  end

  assign o_byte       = shreg_q[127:120];
  assign o_byte_valid = (state_q == SEND);
  assign o_last       = last_q;
  assign o_level      = level_q;
  assign o_overflow   = overflow_q;
  assign o_drop_count = drop_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_hash_byte_streamer.sv
// Self-checking bench for hash_byte_streamer: directed table, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_hash_byte_streamer;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_valid = 1'b0;
  logic [127:0] i_hash = '0;
  logic         i_byte_ready = 1'b0;
  logic [7:0]   o_byte;
  logic         o_byte_valid;
  logic         o_last;
  logic [3:0]   o_level;
  logic         o_overflow;
  logic [15:0]  o_drop_count;
  logic         o_dbg_state;

  hash_byte_streamer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_hash(i_hash),
    .o_byte(o_byte), .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready),
    .o_last(o_last), .o_level(o_level), .o_overflow(o_overflow),
    .o_drop_count(o_drop_count), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: hashes waiting, hash on the wire, and which byte of it.
  logic [127:0] m_fq[$];
  logic [127:0] m_cur;
  bit           m_busy;
  int           m_k;
  int           m_drops;
  bit           m_ovf;
  int           peak;

  typedef struct {
    bit           v;
    logic [127:0] h;
    bit           r;
    bit           ev;
    logic [7:0]   eb;
    bit           el;
    int           elev;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_fq.delete();
    m_cur = '0; m_busy = 0; m_k = 0; m_drops = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    bit pop;
    bit wr;
    int sz;
    pop = 0;
    sz = m_fq.size();
    if (!rst) begin
      model_clear();
      return;
    end
    if (!m_busy) pop = (sz > 0);
    else if (i_byte_ready) begin
      if (m_k < 15) m_k++;
      else if (sz > 0) pop = 1;
      else m_busy = 0;
    end
    wr = i_valid && (sz < DEPTH || pop);
    if (pop) begin
      m_cur = m_fq.pop_front();
      m_k = 0;
      m_busy = 1;
    end
    if (wr) m_fq.push_back(i_hash);
    else if (i_valid) begin
      m_ovf = 1;
      if (m_drops < 65535) m_drops++;
    end
    if (m_fq.size() > peak) peak = m_fq.size();
  endtask

  task automatic model_check();
    chk("valid", 32'(o_byte_valid), 32'(m_busy));
    chk("level", 32'(o_level), 32'(m_fq.size()));
    chk("drops", 32'(o_drop_count), 32'(m_drops));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    if (m_busy) begin
      chk("byte", 32'(o_byte), 32'(m_cur[127-8*m_k -: 8]));
      chk("last", 32'(o_last), 32'(m_k == 15));
    end else begin
      chk("last_idle", 32'(o_last), 32'd0);
    end
  endtask

  task automatic step(input bit v, input logic [127:0] h, input bit r);
    i_valid = v; i_hash = h; i_byte_ready = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b1, 128'hDEAD, 1'b1);
    rst = 1'b1;
  endtask

  function automatic logic [127:0] rnd_hash();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    vec_t tbl[20];
    logic [127:0] seq_h;
    int vcnt, lcnt, d0;
    bool_blk: begin end
    model_clear();
    peak = 0;

    // Reset state, with i_valid asserted to show it is ignored.
    @(negedge clk);
    do_reset();
    chk("rst_valid", 32'(o_byte_valid), 32'd0);
    chk("rst_byte", 32'(o_byte), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_drops", 32'(o_drop_count), 32'd0);

    // Single hash 00..0F: level 1 after the write edge, bytes from the next.
    for (int j = 0; j < 16; j++) seq_h[127-8*j -: 8] = 8'(j);
    for (int j = 0; j < 20; j++) begin
      tbl[j].v = (j == 0); tbl[j].h = seq_h; tbl[j].r = 1'b1;
      tbl[j].elev = (j == 0) ? 1 : 0;
      tbl[j].ev = (j >= 1 && j <= 16);
      tbl[j].eb = (j >= 1 && j <= 16) ? 8'(j - 1) : 8'h00;
      tbl[j].el = (j == 16);
    end
    for (int j = 0; j < 20; j++) begin
      i_valid = tbl[j].v; i_hash = tbl[j].h; i_byte_ready = tbl[j].r;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      i_valid = 1'b0;
      chk($sformatf("tbl%0d_valid", j), 32'(o_byte_valid), 32'(tbl[j].ev));
      chk($sformatf("tbl%0d_level", j), 32'(o_level), 32'(tbl[j].elev));
      chk($sformatf("tbl%0d_last", j), 32'(o_last), 32'(tbl[j].el));
      if (tbl[j].ev) chk($sformatf("tbl%0d_byte", j), 32'(o_byte), 32'(tbl[j].eb));
    end

    // Three hashes back to back: 48 contiguous bytes, level peaks at 2.
    peak = 0; vcnt = 0; lcnt = 0;
    for (int j = 0; j < 3; j++) begin
      step(1'b1, rnd_hash(), 1'b1);
      vcnt += o_byte_valid; lcnt += o_byte_valid & o_last;
    end
    for (int j = 0; j < 55; j++) begin
      step(1'b0, '0, 1'b1);
      vcnt += o_byte_valid; lcnt += o_byte_valid & o_last;
    end
    chk("b2b_peak", 32'(peak), 32'd2);
    chk("b2b_bytes", 32'(vcnt), 32'd48);
    chk("b2b_lasts", 32'(lcnt), 32'd3);

    // Backpressure: ready pattern 1,0,0,1.
    for (int j = 0; j < 140; j++)
      step(j < 4, rnd_hash(), (j % 4 == 0) || (j % 4 == 3));
    chk("bp_drained", 32'(o_byte_valid), 32'd0);

    // Overflow with ready low, then a write coinciding with a byte-15 pop.
    do_reset();
    for (int j = 0; j < 12; j++) step(1'b1, rnd_hash(), 1'b0);
    chk("ovf_drops", 32'(o_drop_count), 32'd3);
    chk("ovf_flag", 32'(o_overflow), 32'd1);
    chk("ovf_level", 32'(o_level), 32'd8);
    lcnt = 0;
    for (int j = 0; j < 40 && !(o_byte_valid && o_last); j++) step(1'b0, '0, 1'b1);
    chk("fp_at_last", 32'(o_byte_valid && o_last), 32'd1);
    d0 = o_drop_count;
    lcnt = 1;
    step(1'b1, rnd_hash(), 1'b1);
    chk("fp_drops", 32'(o_drop_count), 32'(d0));
    chk("fp_level", 32'(o_level), 32'd8);
    for (int j = 0; j < 200; j++) begin
      if (o_byte_valid && o_last) lcnt++;
      step(1'b0, '0, 1'b1);
    end
    chk("ovf_hashes_out", 32'(lcnt), 32'd10);
    chk("ovf_sticky", 32'(o_overflow), 32'd1);

    // Reset at byte 7 of a hash with three more buffered.
    do_reset();
    for (int j = 0; j < 4; j++) step(1'b1, rnd_hash(), 1'b1);
    for (int j = 0; j < 30 && !(m_busy && m_k == 7); j++) step(1'b0, '0, 1'b1);
    chk("mid_level", 32'(o_level), 32'd3);
    chk("mid_byte_idx", 32'(m_busy && m_k == 7), 32'd1);
    do_reset();
    chk("mid_rst_valid", 32'(o_byte_valid), 32'd0);
    chk("mid_rst_level", 32'(o_level), 32'd0);
    vcnt = 0;
    for (int j = 0; j < 25; j++) begin
      step(1'b0, '0, 1'b1);
      vcnt += o_byte_valid;
    end
    chk("mid_no_resume", 32'(vcnt), 32'd0);

    // Random traffic with bursts and random backpressure.
    for (int j = 0; j < 3000; j++) begin
      bit v;
      v = ((j / 200) % 3 == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 14) == 0);
      step(v, rnd_hash(), $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
